// File: rtl/dilithium_params_pkg.sv
// Shared Dilithium constants: parameter sets, coefficient encoding and sampler FSM states.
package dilithium_params_pkg;

    localparam int unsigned TAU_D2 = 39;
    localparam int unsigned TAU_D3 = 49;
    localparam int unsigned TAU_D5 = 60;
    localparam int unsigned N      = 256;

    localparam int unsigned COEF_W  = 2;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned SIGN_W  = 64;
    localparam int unsigned IDX_W   = 9;
    localparam int unsigned STATE_W = 2;

    localparam logic [COEF_W-1:0] COEF_ZERO = 2'b00;
    localparam logic [COEF_W-1:0] COEF_POS  = 2'b01;
    localparam logic [COEF_W-1:0] COEF_NEG  = 2'b11;

    localparam logic [STATE_W-1:0] IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] SIGN   = 2'd1;
    localparam logic [STATE_W-1:0] SAMPLE = 2'd2;
    localparam logic [STATE_W-1:0] DONE   = 2'd3;

    // Map a challenge sign bit to its +/-1 coefficient code.
    function automatic logic [COEF_W-1:0] coef_from_sign(input logic s);
        return s ? COEF_NEG : COEF_POS;
    endfunction

endpackage

// File: rtl/sib_coeff_store.sv
// Challenge polynomial register file: 256 x 2-bit coefficients with clear and
// single-edge swap write (c[i] <= c[j], c[j] <= +/-1, the c[j] write wins when i == j).
module sib_coeff_store
    import dilithium_params_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  we,
    input  logic [BYTE_W-1:0]     idx_i,
    input  logic [BYTE_W-1:0]     idx_j,
    input  logic                  sign_bit,
    output logic [COEF_W*N-1:0]   coefs
);

    logic [COEF_W-1:0] c_q [N];

    // Later non-blocking write to c[j] takes precedence when idx_i == idx_j.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            for (int k = 0; k < int'(N); k++) begin
                c_q[k] <= COEF_ZERO;
            end
        end else if (we) begin
            c_q[idx_i] <= c_q[idx_j];
            c_q[idx_j] <= coef_from_sign(sign_bit);
        end
    end

    for (genvar k = 0; k < int'(N); k++) begin : g_flat
        assign coefs[COEF_W*k +: COEF_W] = c_q[k];
    end

endmodule

// File: rtl/sample_in_ball.sv
// Dilithium SampleInBall: consumes a SHAKE-256 byte stream and builds the TAU-weight challenge.
// Optional SAMPLE_IN_BALL_STATS_EN adds a saturating rejected-byte counter port rej_count.
module sample_in_ball #(
    parameter int unsigned TAU = dilithium_params_pkg::TAU_D2,
    parameter int unsigned N   = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [2*N-1:0]   poly_out,
    output logic             done
`ifdef SAMPLE_IN_BALL_STATS_EN
    ,
    output logic [15:0]      rej_count
`endif
);

    import dilithium_params_pkg::*;

    localparam int unsigned CNT_W = 3;
    localparam logic [IDX_W-1:0] I_START = IDX_W'(N - TAU);
    localparam logic [IDX_W-1:0] I_LAST  = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);

    if (TAU == 0 || TAU > 64 || N != 256) begin : g_bad_param
        $error("sample_in_ball: TAU must be 1..64 and N must be 256");
    end

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [SIGN_W-1:0]  sign;
    logic [CNT_W-1:0]   byte_cnt;
    logic [IDX_W-1:0]   i;

    logic accept;
    logic j_gt_i;
    logic clear_c;
    logic sign_we;
    logic take;
`ifdef SAMPLE_IN_BALL_STATS_EN
    logic rej;
`endif

    assign accept = byte_valid && byte_ready;
    assign j_gt_i = {1'b0, byte_in} > i;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        state_nxt = state;
        clear_c   = 1'b0;
        sign_we   = 1'b0;
        take      = 1'b0;
`ifdef SAMPLE_IN_BALL_STATS_EN
        rej       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    clear_c   = 1'b1;
                    state_nxt = SIGN;
                end
            end
            SIGN: begin
                if (accept) begin
                    sign_we = 1'b1;
                    if (byte_cnt == CNT_LAST) begin
                        state_nxt = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (accept) begin
                    if (j_gt_i) begin
`ifdef SAMPLE_IN_BALL_STATS_EN
                        rej = 1'b1;
`endif
                    end else begin
                        take = 1'b1;
                        if (i == I_LAST) begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and completion flags track the state being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            byte_ready <= 1'b0;
            done       <= 1'b0;
        end else begin
            byte_ready <= (state_nxt == SIGN) || (state_nxt == SAMPLE);
            done       <= (state_nxt == DONE);
        end
    end

    // Sign collection (first byte in the LSBs) and sample index.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sign     <= '0;
            byte_cnt <= '0;
            i        <= '0;
        end else begin
            if (clear_c) begin
                byte_cnt <= '0;
            end
            if (sign_we) begin
                sign[{byte_cnt, 3'b000} +: BYTE_W] <= byte_in;
                byte_cnt <= byte_cnt + CNT_W'(1);
                if (byte_cnt == CNT_LAST) begin
                    i <= I_START;
                end
            end
            if (take) begin
                sign <= sign >> 1;
                if (i != I_LAST) begin
                    i <= i + IDX_W'(1);
                end
            end
        end
    end

`ifdef SAMPLE_IN_BALL_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            rej_count <= '0;
        end else if (clear_c) begin
            rej_count <= '0;
        end else if (rej && (rej_count != 16'hFFFF)) begin
            rej_count <= rej_count + 16'd1;
        end
    end
`endif

    sib_coeff_store u_store (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear_c),
        .we       (take),
        .idx_i    (i[BYTE_W-1:0]),
        .idx_j    (byte_in),
        .sign_bit (sign[0]),
        .coefs    (poly_out)
    );

endmodule

// File: tb/tb_sample_in_ball.sv
// Self-checking bench for sample_in_ball (TAU=39) against a software SampleInBall model.
module tb_sample_in_ball;

    localparam int TAU = 39;
    localparam int N   = 256;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   byte_in = 8'h00;
    logic         byte_valid = 1'b0;
    logic         byte_ready;
    logic [511:0] poly_out;
    logic         done;
`ifdef SAMPLE_IN_BALL_STATS_EN
    logic [15:0]  rej_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   stim[$];
    logic [511:0] exp_poly = '0;
    int           exp_used;
    int           exp_rej;

    sample_in_ball #(.TAU(TAU), .N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .poly_out   (poly_out),
        .done       (done)
`ifdef SAMPLE_IN_BALL_STATS_EN
        ,
        .rej_count  (rej_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int weight(input logic [511:0] p);
        int w = 0;
        for (int k = 0; k < N; k++) begin
            if (p[2*k +: 2] != 2'b00) w++;
        end
        return w;
    endfunction

    function automatic logic [1:0] coef_at(input logic [511:0] p, input int k);
        return p[2*k +: 2];
    endfunction

    // Reference algorithm: signs from the first 8 bytes, then inside-out shuffle with rejection.
    function automatic void model(input logic [7:0] s[$], output logic [511:0] poly,
                                  output int used, output int rej);
        int c[N];
        bit [63:0] sg;
        int pos;
        int nb;
        int j;
        for (int k = 0; k < N; k++) c[k] = 0;
        sg = '0;
        for (int b = 0; b < 8; b++) sg[8*b +: 8] = s[b];
        pos = 8;
        nb  = 0;
        rej = 0;
        for (int i = N - TAU; i < N; i++) begin
            j = int'(s[pos]);
            pos++;
            while (j > i) begin
                rej++;
                j = int'(s[pos]);
                pos++;
            end
            c[i] = c[j];
            c[j] = sg[nb] ? -1 : 1;
            nb++;
        end
        used = pos;
        poly = '0;
        for (int k = 0; k < N; k++) begin
            poly[2*k +: 2] = (c[k] == 0) ? 2'b00 : ((c[k] == 1) ? 2'b01 : 2'b11);
        end
    endfunction

    // Continuous check of the result whenever the DUT claims completion.
    always @(negedge clock) begin
        if (reset && done) begin
            chk("poly_at_done", poly_out, exp_poly);
            chk("ready_low_in_done", 512'(byte_ready), 512'(0));
            chk("weight_at_done", 512'(weight(poly_out)), 512'(TAU));
        end
    end

    task automatic fill(input int n, input logic [7:0] v);
        for (int k = 0; k < n; k++) stim.push_back(v);
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) stim.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run(input string name, input bit gaps, input int abort_at);
        int k;
        int extra;
        model(stim, exp_poly, exp_used, exp_rej);
        @(negedge clock);
        chk({name, "_ready_idle"}, 512'(byte_ready), 512'(0));
        start = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if (done) break;
            if (abort_at >= 0 && k == abort_at) begin
                reset      = 1'b0;
                byte_valid = 1'b1;
                byte_in    = stim[k];
                @(negedge clock);
                chk({name, "_abort_done"}, 512'(done), 512'(0));
                chk({name, "_abort_ready"}, 512'(byte_ready), 512'(0));
                chk({name, "_abort_poly"}, poly_out, 512'(0));
                reset      = 1'b1;
                start      = 1'b0;
                byte_valid = 1'b0;
                return;
            end
            byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            byte_in    = (k < stim.size()) ? stim[k] : 8'h00;
            if (byte_valid && byte_ready) k++;
        end
        chk({name, "_done_reached"}, 512'(done), 512'(1));
        chk({name, "_bytes_used"}, 512'(k), 512'(exp_used));
`ifdef SAMPLE_IN_BALL_STATS_EN
        chk({name, "_rej_count"}, 512'(rej_count), 512'(exp_rej));
`endif
        // Keep start high and offer more bytes: result must hold, nothing consumed.
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            byte_valid = 1'b1;
            byte_in    = 8'h00;
            if (byte_ready) extra++;
            @(negedge clock);
        end
        chk({name, "_done_held"}, 512'(done), 512'(1));
        chk({name, "_no_extra_bytes"}, 512'(extra), 512'(0));
        start      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clock);
        chk({name, "_done_cleared"}, 512'(done), 512'(0));
        chk({name, "_poly_held_idle"}, poly_out, exp_poly);
    endtask

    initial begin
        logic [511:0] p;
        int u;
        int r;

        repeat (3) @(negedge clock);
        chk("reset_done", 512'(done), 512'(0));
        chk("reset_ready", 512'(byte_ready), 512'(0));
        chk("reset_poly", poly_out, 512'(0));
`ifdef SAMPLE_IN_BALL_STATS_EN
        chk("reset_rej_count", 512'(rej_count), 512'(0));
`endif
        reset = 1'b1;

        // All-zero signs and samples.
        stim.delete(); fill(8, 8'h00); fill(45, 8'h00);
        model(stim, p, u, r);
        chk("pin_zero_c0", 512'(coef_at(p, 0)), 512'(2'b01));
        chk("pin_zero_c217", 512'(coef_at(p, 217)), 512'(2'b00));
        chk("pin_zero_c218", 512'(coef_at(p, 218)), 512'(2'b01));
        chk("pin_zero_c255", 512'(coef_at(p, 255)), 512'(2'b01));
        chk("pin_zero_weight", 512'(weight(p)), 512'(39));
        run("zero", 1'b0, -1);

        // All-ones signs: same positions, negative.
        stim.delete(); fill(8, 8'hFF); fill(45, 8'h00);
        model(stim, p, u, r);
        chk("pin_neg_c0", 512'(coef_at(p, 0)), 512'(2'b11));
        chk("pin_neg_c217", 512'(coef_at(p, 217)), 512'(2'b00));
        chk("pin_neg_c240", 512'(coef_at(p, 240)), 512'(2'b11));
        run("neg", 1'b0, -1);

        // Rejections: 0xFF and 218 rejected at i=217, then 5 accepted.
        stim.delete(); fill(8, 8'h00);
        stim.push_back(8'hFF); stim.push_back(8'hDA); stim.push_back(8'h05);
        fill(38, 8'h00); fill(6, 8'h00);
        model(stim, p, u, r);
        chk("pin_rej_c5", 512'(coef_at(p, 5)), 512'(2'b01));
        chk("pin_rej_c217", 512'(coef_at(p, 217)), 512'(2'b00));
        chk("pin_rej_c218", 512'(coef_at(p, 218)), 512'(2'b00));
        chk("pin_rej_count", 512'(r), 512'(2));
        chk("pin_rej_used", 512'(u), 512'(49));
        run("reject", 1'b0, -1);
        run("reject_gaps", 1'b1, -1);

        // j == i every step: c[217..255] = +1.
        stim.delete(); fill(8, 8'h00);
        for (int v = 217; v <= 255; v++) stim.push_back(8'(v));
        fill(6, 8'h00);
        model(stim, p, u, r);
        chk("pin_diag_c217", 512'(coef_at(p, 217)), 512'(2'b01));
        chk("pin_diag_c0", 512'(coef_at(p, 0)), 512'(2'b00));
        run("diag", 1'b0, -1);

        // Abort mid-sample, then complete runs on pseudo-random streams.
        stim.delete(); fill_random(308);
        run("abort", 1'b0, 8 + 19);
        stim.delete(); fill_random(308);
        run("random", 1'b0, -1);
        stim.delete(); fill_random(308);
        run("random_gaps", 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_in_ball.md
Name: sample_in_ball

Overview:
- Dilithium challenge sampler (SampleInBall). Sits directly downstream of the SHAKE-256 core and consumes its squeezed output as a byte stream.
- Builds challenge polynomial c: exactly TAU coefficients of ±1, all others 0.
- Uses an inside-out Fisher-Yates shuffle with rejection sampling.
- Result feeds the polynomial multiply/NTT stage as a packed 512-bit vector.

Parameters:
- TAU, 39, number of nonzero coefficients (39/49/60 for Dilithium2/3/5); legal range 1..64.
- N, 256, polynomial length; fixed, not to be overridden.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  level; sampled only in IDLE.
- byte_in  input  8  next SHAKE-256 output byte, stream order.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  block accepts byte_in this cycle.
- poly_out  output  512  coefficient k at [2k+1:2k]; 2'b00 = 0, 2'b01 = +1, 2'b11 = -1.
- done  output  1  poly_out complete and stable.
- rej_count  output  16  present only with SAMPLE_IN_BALL_STATS_EN.

Behaviour:
- Reset: clock edge with reset==0 sets state IDLE, byte_ready=0, done=0, poly_out=0, sign register=0, byte counter=0, i=0. Reset mid-operation aborts immediately; no partial result is retained.
- Byte transfer: a byte is accepted on an edge where byte_valid && byte_ready. byte_ready is a registered function of state: 1 in SIGN and SAMPLE, 0 elsewhere. byte_ready does not depend combinationally on byte_valid.
- IDLE:
  - done=0.
  - On start=1: clear all coefficients to 0, byte counter=0, then go to SIGN.
- SIGN:
  - Accept 8 bytes. Byte b goes to sign[8b+7:8b], so the first byte is the LSBs.
  - After the 8th accepted byte: i = N-TAU, then go to SAMPLE.
- SAMPLE, per accepted byte j (unsigned 0..255):
  - j > i: reject. No coefficient change, i unchanged, rej_count+1.
  - j <= i: in the same edge, c[i] <= old c[j] and c[j] <= (sign[0] ? -1 : +1). Shift sign right by 1; i <= i+1.
  - j == i: the c[j] write has priority, so c[i] becomes ±1 from the sign bit.
  - If the accepted i was 255, go to DONE on that edge instead of incrementing.
- No valid byte: the FSM holds its state; gaps in byte_valid are legal in SIGN and SAMPLE.
- DONE:
  - done=1; poly_out holds the final c.
  - byte_ready=0; extra upstream bytes are not consumed.
  - Remain in DONE while start=1. On start=0, go to IDLE.
  - done is level-high until then; poly_out stays valid until the next start.
- poly_out is driven directly from the coefficient registers. It is only meaningful when done=1.
- start asserted in SIGN/SAMPLE/DONE has no effect beyond the DONE exit rule.
- Latency: 8 + TAU + (rejected bytes) accepted-byte cycles from start, +1 edge to IDLE→SIGN, +0 to done (done rises with the final accepting edge's state change, visible the next cycle).
- Invariant at done: exactly TAU coefficients nonzero.
- Widths: i is 9 bits internally; the comparison j > i is unsigned; sign register is 64 bits.

Optional Feature:
- Macro: SAMPLE_IN_BALL_STATS_EN.
- Defined:
  - rej_count port exists (16 bits).
  - Cleared to 0 at start in IDLE; increments per rejected byte, saturating at 16'hFFFF.
  - Holds its value through DONE; reset clears it.
- Undefined: no port, no counter logic. Functional behaviour is otherwise identical.

Decomposition:
- Shared package dilithium_params_pkg:
  - TAU_D2/TAU_D3/TAU_D5 constants (39/49/60).
  - N=256.
  - Coefficient encoding constants COEF_ZERO/COEF_POS/COEF_NEG.
  - FSM state encoding localparams IDLE/SIGN/SAMPLE/DONE.
- One sub-module: sib_coeff_store.
  - 256×2-bit register file, clear, single-edge swap-write (read c[j], write c[i] and c[j] with c[j] priority).
  - Flattened 512-bit output.

Test Plan:
- TAU=39; 8 sign bytes 0x00, then 39 bytes 0x00 → done; c[0]=+1, c[217]=0, c[218..255]=+1, all others 0; weight 39.
- TAU=39; sign bytes all 0xFF, then bytes 0x00 ×39 → same pattern with -1 (2'b11).
- Rejection: after sign bytes, feed 0xFF, 0xDA (218>217), 0x05, then 38 × 0x00 → first two rejected; c[217] receives old c[5] (0); c[5] set; rej_count=2 with SAMPLE_IN_BALL_STATS_EN.
- i==j case: sign 0x00..., bytes 217,218,...,255 → c[217..255]=+1, others 0.
- Backpressure/gaps: random byte_valid deassertion → same result as the gapless run; byte_ready=0 in IDLE and DONE; no byte consumed after done.
- Reset mid-SAMPLE (reset=0 for 1 cycle at the 20th sample byte) → next edge: IDLE, done=0, poly_out=0; a subsequent full run matches the golden model (software SampleInBall from a SHAKE-256 KAT).
